score_disp_scan: RTL and testbench
==================================

# score_disp_scan

Score keeper and multiplexed display scanner for the ping-pong game. It holds both players' scores as two-digit BCD values and advances them on point pulses from the game logic. It time-multiplexes the four score digits onto one shared 4-bit digit bus and an active-low digit-enable vector. The digit bus is the `D` input of the segment decoders; this block is the producer (writer) side of that interface, and the decoders consume it combinationally.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit slot is held; legal range 2..2^20.
- `WIN_SCORE`, default 11: score (decimal, 1..99) at which a player wins.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `inc_p1` in 1: single-cycle pulse, point to player 1.
- `inc_p2` in 1: single-cycle pulse, point to player 2.
- `clr` in 1: synchronous new-game clear.
- `digit` out 4: BCD digit to segment decoders; 4'hF = blank.
- `an_n` out 4: active-low digit enables; bit0 = P1 ones, bit1 = P1 tens, bit2 = P2 ones, bit3 = P2 tens.
- `game_over` out 1: high once a winner exists.
- `winner` out 2: 2'b01 = P1, 2'b10 = P2, 2'b11 = simultaneous, 2'b00 = none.

## Operation
- Each score is stored as a tens nibble and a ones nibble, each 0..9.
  - An increment sets ones to 9→0 with a carry into tens.
  - At 99 the score saturates; further increments are ignored.
- Increments are ignored while `game_over`=1.
- `inc_p1` and `inc_p2` asserted in the same cycle both apply.
- `clr` has priority over both increments in the same cycle. It zeroes both scores, `game_over` and `winner`. It does not disturb the scan prescaler or slot.
- Win check uses the post-increment values.
  - If exactly one score equals `WIN_SCORE`, `game_over` is set and `winner` is set to that player.
  - If both reach it in the same cycle, `winner`=2'b11.
  - Both outputs stay until `clr` or reset.
- Scan prescaler counts 0..`REFRESH_DIV`-1 and wraps. On the wrap cycle, slot advances 0→1→2→3→0.
- Slot mapping:
  - Slot 0: P1 ones, `an_n`=4'b1110.
  - Slot 1: P1 tens, 4'b1101.
  - Slot 2: P2 ones, 4'b1011.
  - Slot 3: P2 tens, 4'b0111.
- Leading-zero blanking: in slot 1 or 3, if the tens nibble is 0, then `digit`=4'hF and `an_n`=4'b1111. Ones digits are never blanked; score 0 displays "0".
- At most one `an_n` bit is low in any cycle.

## Timing
- Reset values (asynchronous, on `rst_n` low):
  - Scores 00/00, prescaler 0, slot 0.
  - `digit`=4'h0, `an_n`=4'b1111, `game_over`=0, `winner`=2'b00.
- `digit` and `an_n` are registered and reflect the slot and score values held during the previous cycle.
  - First rising edge after `rst_n` deasserts: `an_n`=4'b1110, `digit`=0.
- Score registers update on the edge that samples `inc_px`. The displayed digit changes on the following edge if that slot is active.
- `game_over`/`winner` assert on the same edge as the winning score update. Total latency from pulse to flag is one cycle.
- Slot dwell is exactly `REFRESH_DIV` cycles. The outputs switch one cycle after the prescaler wraps.
- `rst_n` asserted mid-slot or mid-game returns all state to reset values immediately. There is no partial digit afterwards.
- `inc_px` held high for multiple cycles counts once per cycle. Pulse width is the caller's responsibility.

## Test plan
- Reset with `REFRESH_DIV`=4, no stimulus, 20 cycles:
  - `an_n` cycles 1110, 1111, 1011, 1111, each held 4 cycles.
  - `digit` is 0, F, 0, F, since tens are blanked.
- 9 pulses on `inc_p1`, then one more:
  - After 9, P1 = 09 and slot 1 is blanked.
  - After 10, P1 = 10; slot 0 shows 0 and slot 1 shows 1 with `an_n`=1101.
- `WIN_SCORE`=11, drive P1 to 11:
  - `game_over`=1 and `winner`=01 on the edge of the 11th pulse.
  - A further `inc_p1` or `inc_p2` leaves the scores unchanged.
- Both at 10, `inc_p1` and `inc_p2` in the same cycle: both become 11, `winner`=11.
- `clr` and `inc_p2` in the same cycle with P2=05: P2=00, game flags cleared, scan slot and prescaler uninterrupted.
- `WIN_SCORE`=99, drive P2 through 99: saturates at 99 with `game_over`=1. Assert `rst_n`=0 mid-slot: outputs return to reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/score_disp_scan_if.sv
// Signal bundle between the game logic, the score keeper and the segment decoders.
// The slave side is the score keeper; the master side drives points and watches the display.
interface score_disp_scan_if;
    logic       inc_p1;
    logic       inc_p2;
    logic       clr;
    logic [3:0] digit;
    logic [3:0] an_n;
    logic       game_over;
    logic [1:0] winner;

    modport master (
        output inc_p1, inc_p2, clr,
        input  digit, an_n, game_over, winner
    );

    modport slave (
        input  inc_p1, inc_p2, clr,
        output digit, an_n, game_over, winner
    );
endinterface

// File: rtl/score_disp_scan.sv
// Two-player BCD score keeper with win detection and a four-digit multiplexed display scanner.
// Display outputs are registered and show the slot/score values held in the previous cycle.
module score_disp_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter int WIN_SCORE   = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    score_disp_scan_if.slave bus
);
    localparam int            PW         = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [7:0]    WIN_BCD    = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};
    localparam logic [7:0]    MAX_BCD    = 8'h99;
    localparam logic [3:0]    BLANK      = 4'hF;

    typedef enum logic [1:0] {
        SLOT_P1_ONES = 2'd0,
        SLOT_P1_TENS = 2'd1,
        SLOT_P2_ONES = 2'd2,
        SLOT_P2_TENS = 2'd3
    } slot_t;

    // Scores are packed {tens, ones}, each nibble 0..9.
    logic [7:0]    r_p1_score;
    logic [7:0]    r_p2_score;
    logic          r_game_over;
    logic [1:0]    r_winner;
    logic [PW-1:0] r_presc;
    slot_t         r_slot;
    logic [3:0]    r_digit;
    logic [3:0]    r_an_n;

    logic [7:0]    w_p1_next;
    logic [7:0]    w_p2_next;
    logic          w_p1_win;
    logic          w_p2_win;
    logic [3:0]    w_digit;
    logic [3:0]    w_an_n;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] res;
        if (v == MAX_BCD) begin
            res = v;
        end else if (v[3:0] == 4'd9) begin
            res = {v[7:4] + 4'd1, 4'd0};
        end else begin
            res = {v[7:4], v[3:0] + 4'd1};
        end
        return res;
    endfunction

    // Post-increment scores and the win test made against them.
    always_comb begin
        w_p1_next = r_p1_score;
        w_p2_next = r_p2_score;
        if (!r_game_over && bus.inc_p1) begin
            w_p1_next = bcd_inc(r_p1_score);
        end else begin
            w_p1_next = r_p1_score;
        end
        if (!r_game_over && bus.inc_p2) begin
            w_p2_next = bcd_inc(r_p2_score);
        end else begin
            w_p2_next = r_p2_score;
        end
        w_p1_win = (w_p1_next == WIN_BCD);
        w_p2_win = (w_p2_next == WIN_BCD);
    end

    // Score and game-result registers; clr outranks any point in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p1_score  <= 8'h00;
            r_p2_score  <= 8'h00;
            r_game_over <= 1'b0;
            r_winner    <= 2'b00;
        end else if (bus.clr) begin
            r_p1_score  <= 8'h00;
            r_p2_score  <= 8'h00;
            r_game_over <= 1'b0;
            r_winner    <= 2'b00;
        end else begin
            r_p1_score <= w_p1_next;
            r_p2_score <= w_p2_next;
            if (!r_game_over && (w_p1_win || w_p2_win)) begin
                r_game_over <= 1'b1;
                r_winner    <= {w_p2_win, w_p1_win};
            end
        end
    end

    // Scan prescaler and slot sequencer; untouched by clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_slot  <= SLOT_P1_ONES;
        end else if (r_presc == PRESC_LAST) begin
            r_presc <= '0;
            case (r_slot)
                SLOT_P1_ONES: r_slot <= SLOT_P1_TENS;
                SLOT_P1_TENS: r_slot <= SLOT_P2_ONES;
                SLOT_P2_ONES: r_slot <= SLOT_P2_TENS;
                SLOT_P2_TENS: r_slot <= SLOT_P1_ONES;
                default:      r_slot <= SLOT_P1_ONES;
            endcase
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Digit selection with leading-zero blanking of the tens positions.
    always_comb begin
        w_digit = BLANK;
        w_an_n  = 4'b1111;
        case (r_slot)
            SLOT_P1_ONES: begin
                w_digit = r_p1_score[3:0];
                w_an_n  = 4'b1110;
            end
            SLOT_P1_TENS: begin
                if (r_p1_score[7:4] == 4'd0) begin
                    w_digit = BLANK;
                    w_an_n  = 4'b1111;
                end else begin
                    w_digit = r_p1_score[7:4];
                    w_an_n  = 4'b1101;
                end
            end
            SLOT_P2_ONES: begin
                w_digit = r_p2_score[3:0];
                w_an_n  = 4'b1011;
            end
            SLOT_P2_TENS: begin
                if (r_p2_score[7:4] == 4'd0) begin
                    w_digit = BLANK;
                    w_an_n  = 4'b1111;
                end else begin
                    w_digit = r_p2_score[7:4];
                    w_an_n  = 4'b0111;
                end
            end
            default: begin
                w_digit = BLANK;
                w_an_n  = 4'b1111;
            end
        endcase
    end

    // Registered display drive toward the segment decoders.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit <= 4'h0;
            r_an_n  <= 4'b1111;
        end else begin
            r_digit <= w_digit;
            r_an_n  <= w_an_n;
        end
    end

    assign bus.digit     = r_digit;
    assign bus.an_n      = r_an_n;
    assign bus.game_over = r_game_over;
    assign bus.winner    = r_winner;
endmodule

// File: tb/tb_score_disp_scan.sv
// Scoreboard bench for score_disp_scan: two instances (win at 11 and at 99) share one clock.
// An integer-score reference model queues the expected outputs of every cycle.
module tb_score_disp_scan;
    localparam int DIV   = 4;
    localparam int WIN_A = 11;
    localparam int WIN_B = 99;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    score_disp_scan_if ifa ();
    score_disp_scan_if ifb ();

    score_disp_scan #(.REFRESH_DIV(DIV), .WIN_SCORE(WIN_A)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    score_disp_scan #(.REFRESH_DIV(DIV), .WIN_SCORE(WIN_B)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    typedef struct {
        int         inst;
        logic [3:0] digit;
        logic [3:0] an_n;
        logic       go;
        logic [1:0] winner;
    } exp_t;

    exp_t       sb_q[$];
    int         m_s1[2];
    int         m_s2[2];
    int         m_presc[2];
    int         m_slot[2];
    logic       m_go[2];
    logic [1:0] m_win[2];
    int         n_checks = 0;
    int         n_pass   = 0;
    string      phase    = "init";

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s/%s: got %0h, want %0h", phase, tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_s1[k]    = 0;
            m_s2[k]    = 0;
            m_presc[k] = 0;
            m_slot[k]  = 0;
            m_go[k]    = 1'b0;
            m_win[k]   = 2'b00;
        end
    endtask

    // Expected outputs after the coming edge: display from current state, flags from updated state.
    task automatic model_step(input int k, input bit i1, input bit i2, input bit c);
        exp_t e;
        int   win;
        bit   w1;
        bit   w2;
        win    = (k == 0) ? WIN_A : WIN_B;
        e.inst = k;
        case (m_slot[k])
            0: begin e.digit = 4'(m_s1[k] % 10); e.an_n = 4'b1110; end
            1: begin
                if (m_s1[k] / 10 == 0) begin e.digit = 4'hF; e.an_n = 4'b1111; end
                else begin e.digit = 4'(m_s1[k] / 10); e.an_n = 4'b1101; end
            end
            2: begin e.digit = 4'(m_s2[k] % 10); e.an_n = 4'b1011; end
            default: begin
                if (m_s2[k] / 10 == 0) begin e.digit = 4'hF; e.an_n = 4'b1111; end
                else begin e.digit = 4'(m_s2[k] / 10); e.an_n = 4'b0111; end
            end
        endcase
        if (c) begin
            m_s1[k]  = 0;
            m_s2[k]  = 0;
            m_go[k]  = 1'b0;
            m_win[k] = 2'b00;
        end else if (!m_go[k]) begin
            if (i1 && m_s1[k] < 99) m_s1[k]++;
            if (i2 && m_s2[k] < 99) m_s2[k]++;
            w1 = (m_s1[k] == win);
            w2 = (m_s2[k] == win);
            if (w1 || w2) begin
                m_go[k]  = 1'b1;
                m_win[k] = {w2, w1};
            end
        end
        if (m_presc[k] == DIV - 1) begin
            m_presc[k] = 0;
            m_slot[k]  = (m_slot[k] + 1) % 4;
        end else begin
            m_presc[k]++;
        end
        e.go     = m_go[k];
        e.winner = m_win[k];
        sb_q.push_back(e);
    endtask

    task automatic drive(input bit a1, input bit a2, input bit ac,
                         input bit b1, input bit b2, input bit bc);
        ifa.inc_p1 = a1; ifa.inc_p2 = a2; ifa.clr = ac;
        ifb.inc_p1 = b1; ifb.inc_p2 = b2; ifb.clr = bc;
    endtask

    task automatic step(input bit a1, input bit a2, input bit ac,
                        input bit b1, input bit b2, input bit bc);
        exp_t       e;
        logic [3:0] od;
        logic [3:0] oa;
        logic       og;
        logic [1:0] ow;
        drive(a1, a2, ac, b1, b2, bc);
        model_step(0, a1, a2, ac);
        model_step(1, b1, b2, bc);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.inst == 0) begin
                od = ifa.digit; oa = ifa.an_n; og = ifa.game_over; ow = ifa.winner;
            end else begin
                od = ifb.digit; oa = ifb.an_n; og = ifb.game_over; ow = ifb.winner;
            end
            chk($sformatf("digit%0d", e.inst),  {4'd0, od}, {4'd0, e.digit});
            chk($sformatf("an_n%0d", e.inst),   {4'd0, oa}, {4'd0, e.an_n});
            chk($sformatf("go%0d", e.inst),     {7'd0, og}, {7'd0, e.go});
            chk($sformatf("winner%0d", e.inst), {6'd0, ow}, {6'd0, e.winner});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset();
        chk("rst_digit0", {4'd0, ifa.digit}, 8'h00);
        chk("rst_an_n0",  {4'd0, ifa.an_n},  8'h0F);
        chk("rst_go0",    {7'd0, ifa.game_over}, 8'h00);
        chk("rst_win0",   {6'd0, ifa.winner}, 8'h00);
        chk("rst_digit1", {4'd0, ifb.digit}, 8'h00);
        chk("rst_an_n1",  {4'd0, ifb.an_n},  8'h0F);
        chk("rst_go1",    {7'd0, ifb.game_over}, 8'h00);
        chk("rst_win1",   {6'd0, ifb.winner}, 8'h00);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        phase = "reset";
        check_reset();
        rst_n = 1'b1;

        phase = "scan";
        idle(20);

        phase = "p1to9";
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(8);

        phase = "p1to10";
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(8);

        phase = "p1win";
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(8);

        phase = "tie";
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(8);

        phase = "clr";
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(10);

        phase = "sat";
        for (int i = 0; i < 105; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(18);

        phase = "async";
        #2;
        rst_n = 1'b0;
        #1;
        check_reset();
        model_reset();
        @(posedge clk);
        #1;
        check_reset();
        rst_n = 1'b1;
        phase = "after_rst";
        idle(12);

        chk("sb_empty", 8'(sb_q.size()), 8'h00);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
